data_detransposer: RTL

DATA_DETRANSPOSER -- requirements
Module: data_detransposer

---
 rtl/data_detransposer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_detransposer.sv
// Reads prec bit-planes from the MVU output RAM into a plane buffer, then
// streams the NUM_WORDS elements back out one at a time as XLEN-bit words,
// zero- or sign-extended, through a valid/ready handshake.
module data_detransposer #(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0]                    prec,
  input  logic [MVU_ADDR_LEN-1:0]       baddr,
  input  logic                          is_signed,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mvu_rd_en,
  output logic [MVU_ADDR_LEN-1:0]       mvu_rd_addr,
  input  logic [MVU_DATA_LEN-1:0]       mvu_rd_word,
  output logic                          ovalid,
  input  logic                          oready,
  output logic [XLEN-1:0]               oword,
  output logic [$clog2(NUM_WORDS)-1:0]  oidx
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int ROW_W = $clog2(MAX_DATA_PREC);

  typedef enum logic [1:0] {IDLE, READ, WAIT, EMIT} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [4:0]                prec_q;
  logic [MVU_ADDR_LEN-1:0]   baddr_q;
  logic                      signed_q;
  logic [4:0]                rd_cnt;
  logic                      cap_en;
  logic [ROW_W-1:0]          cap_row;
  logic [MVU_DATA_LEN-1:0]   planes [MAX_DATA_PREC];
  logic [IDX_W-1:0]          oidx_q;
  logic                      done_q;
  logic                      start_ok;
  logic                      last_rd;
  logic                      hs;
  logic                      last_elem;

  assign start_ok    = start && (prec != 5'd0) && (int'(prec) <= MAX_DATA_PREC);
  assign last_rd     = (rd_cnt == prec_q - 5'd1);
  assign hs          = (state == EMIT) && oready;
  assign last_elem   = (oidx_q == IDX_W'(NUM_WORDS - 1));

  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign mvu_rd_en   = (state == READ);
  assign mvu_rd_addr = baddr_q + MVU_ADDR_LEN'(rd_cnt);
  assign ovalid      = (state == EMIT);
  assign oidx        = oidx_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: read planes, one cycle for the last plane to land, then emit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = READ;
      READ: if (last_rd) state_nxt = WAIT;
      WAIT: state_nxt = EMIT;
      EMIT: if (hs && last_elem) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch transfer parameters only when a legal start is accepted from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      prec_q   <= 5'd0;
      baddr_q  <= '0;
      signed_q <= 1'b0;
    end else if (state == IDLE && start_ok) begin
      prec_q   <= prec;
      baddr_q  <= baddr;
      signed_q <= is_signed;
    end
  end

  // Plane read counter, doubles as the address offset during READ
  always_ff @(posedge clk) begin
    if (rst)                          rd_cnt <= 5'd0;
    else if (state == IDLE && start_ok) rd_cnt <= 5'd0;
    else if (state == READ && !last_rd) rd_cnt <= rd_cnt + 5'd1;
  end

  // Delay the read strobe and row number to line up with the RAM's one-cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_en  <= 1'b0;
      cap_row <= '0;
    end else begin
      cap_en  <= mvu_rd_en;
      cap_row <= rd_cnt[ROW_W-1:0];
    end
  end

  // Plane buffer: contents are fully rewritten by each transfer so no reset
  always_ff @(posedge clk) begin
    if (cap_en) planes[cap_row] <= mvu_rd_word;
  end

  // Element index advances on each accepted output and wraps for the next transfer
  always_ff @(posedge clk) begin
    if (rst) oidx_q <= '0;
    else if (hs) begin
      if (last_elem) oidx_q <= '0;
      else           oidx_q <= oidx_q + IDX_W'(1);
    end
  end

  // Done pulses in the cycle after the final handshake
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= hs && last_elem;
  end

  // Assemble the element: row 0 is the MSB, rows at or above prec are ignored
  always_comb begin
    logic             ext;
    logic [ROW_W-1:0] row;
    oword = '0;
    row   = '0;
    ext   = signed_q & planes[0][oidx_q];
    for (int b = 0; b < XLEN; b++) begin
      if (b < int'(prec_q)) begin
        row      = ROW_W'(int'(prec_q) - 1 - b);
        oword[b] = planes[row][oidx_q];
      end else begin
        oword[b] = ext;
      end
    end
  end

endmodule
